// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port sync_ram: write bursts from a stream, read bursts into a 4-deep FIFO.
// Optional RAM_BOUND_CHK_EN rejects bursts that would run past the top address (err pulse, no access).
module ram_burst_master #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

    localparam logic [ADDR_W-1:0] ONE_A = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;
    logic [ADDR_W-1:0] beats_left_q, beats_left_d;
    logic [ADDR_W-1:0] rd_left_q, rd_left_d;
    logic              issued_all_q, issued_all_d;
    logic [1:0]        vld_pipe_q, vld_pipe_d;
    logic [DATA_W-1:0] fifo_q [4];
    logic [DATA_W-1:0] fifo_d [4];
    logic [1:0]        wp_q, wp_d, rp_q, rp_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              err_q, err_d;
    logic              push, pop;
    logic [3:0]        occ;

`ifdef RAM_BOUND_CHK_EN
    logic [ADDR_W:0] span;
    assign span = {1'b0, cmd_addr} + {1'b0, cmd_len};
`endif

    assign cmd_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == WR);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign rd_valid  = (cnt_q != 3'd0);
    assign rd_data   = fifo_q[rp_q];
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;

    assign pop  = rd_valid & rd_ready;
    assign push = vld_pipe_q[1];
    // Reads already issued but not yet in the FIFO still need a slot reserved.
    assign occ  = {1'b0, cnt_q} + {3'b0, vld_pipe_q[0]} + {3'b0, vld_pipe_q[1]};

    always_comb begin
        state_d      = state_q;
        addr_ptr_d   = addr_ptr_q;
        beats_left_d = beats_left_q;
        rd_left_d    = rd_left_q;
        issued_all_d = issued_all_q;
        vld_pipe_d   = {vld_pipe_q[0], 1'b0};
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        err_d        = 1'b0;
        fifo_d       = fifo_q;
        wp_d         = wp_q;
        rp_d         = rp_q;
        cnt_d        = cnt_q + {2'b0, push} - {2'b0, pop};

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_ptr_d   = cmd_addr;
                    beats_left_d = cmd_len;
                    rd_left_d    = cmd_len;
                    issued_all_d = 1'b0;
`ifdef RAM_BOUND_CHK_EN
                    if (span[ADDR_W]) err_d = 1'b1;
                    else
`endif
                    state_d = cmd_wr ? WR : RD;
                end
            end
            WR: begin
                if (wr_valid) begin
                    ram_we_d     = 1'b1;
                    ram_addr_d   = addr_ptr_q;
                    ram_din_d    = wr_data;
                    addr_ptr_d   = addr_ptr_q + ONE_A;
                    beats_left_d = beats_left_q - ONE_A;
                    if (beats_left_q == '0) state_d = DONE;
                end
            end
            RD: begin
                if (!issued_all_q && (occ <= 4'd3 + {3'b0, pop})) begin
                    ram_addr_d    = addr_ptr_q;
                    vld_pipe_d[0] = 1'b1;
                    addr_ptr_d    = addr_ptr_q + ONE_A;
                    beats_left_d  = beats_left_q - ONE_A;
                    if (beats_left_q == '0) issued_all_d = 1'b1;
                end
                if (pop) begin
                    if (rd_left_q == '0) state_d = DONE;
                    else                 rd_left_d = rd_left_q - ONE_A;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            fifo_d[wp_q] = ram_dout;
            wp_d         = wp_q + 2'd1;
        end
        if (pop) rp_d = rp_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_ptr_q   <= '0;
            beats_left_q <= '0;
            rd_left_q    <= '0;
            issued_all_q <= 1'b0;
            vld_pipe_q   <= '0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
            wp_q         <= '0;
            rp_q         <= '0;
            cnt_q        <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_ptr_q   <= addr_ptr_d;
            beats_left_q <= beats_left_d;
            rd_left_q    <= rd_left_d;
            issued_all_q <= issued_all_d;
            vld_pipe_q   <= vld_pipe_d;
            fifo_q       <= fifo_d;
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            cnt_q        <= cnt_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural sync_ram attached.
module tb_ram_burst_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [3:0] cmd_addr, cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic       busy, done, err;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din, ram_dout;

    logic [7:0] mem [16];
    int tests = 0, fails = 0;
    int cyc = 0, acc_cyc = 0, first_rv = -1, first_pop = -1, last_pop = -1;
    int done_cnt = 0, err_cnt = 0;
    logic [7:0] rdq [$];
    logic [3:0] wq_addr [$];
    logic [7:0] wq_data [$];

    ram_burst_master #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // sync_ram: write-on-we, registered read
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    always @(posedge clk) begin
        cyc++;
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (rd_valid && first_rv < 0) first_rv = cyc;
        if (rd_valid && rd_ready) begin
            rdq.push_back(rd_data);
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (ram_we) begin
            wq_addr.push_back(ram_addr);
            wq_data.push_back(ram_din);
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue_cmd(input logic wr, input logic [3:0] a, input logic [3:0] l);
        int n = 0;
        cmd_wr = wr; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin tick(); n++; end
        chk("cmd_ready", {31'b0, cmd_ready}, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wr_beat(input logic [7:0] d);
        int n = 0;
        wr_valid = 1'b1; wr_data = d;
        while (!wr_ready && n < 100) begin tick(); n++; end
        chk("wr_ready", {31'b0, wr_ready}, 1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 100) begin tick(); n++; end
        chk("idle", {31'b0, cmd_ready}, 1);
    endtask

    task automatic read_burst(input logic [3:0] a, input logic [3:0] l, input int mode);
        int n = 0;
        rdq.delete(); first_rv = -1; first_pop = -1;
        rd_ready = 1'b1;
        issue_cmd(1'b0, a, l);
        while (rdq.size() < int'(l) + 1 && n < 300) begin
            rd_ready = (mode == 0) || (n % 3 == 0);
            tick(); n++;
        end
        rd_ready = 1'b0;
        wait_idle();
        chk("rd_count", rdq.size(), int'(l) + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 1'b1; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_len = 0;
        wr_valid = 0; wr_data = 0; rd_ready = 0;
        tick(); tick();
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
        chk("rst_wr_ready", {31'b0, wr_ready}, 0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 0);
        chk("rst_rd_data", {24'b0, rd_data}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_ram_we", {31'b0, ram_we}, 0);
        chk("rst_ram_addr", {28'b0, ram_addr}, 0);
        chk("rst_ram_din", {24'b0, ram_din}, 0);
        rst = 1'b0;
        tick();

        // write then read, addr 3 len 1
        wq_addr.delete(); wq_data.delete();
        issue_cmd(1'b1, 4'd3, 4'd1);
        chk("wr_lat_ready", {31'b0, wr_ready}, 1);
        chk("wr_busy", {31'b0, busy}, 1);
        wr_beat(8'd25);
        wr_beat(8'd40);
        wait_idle();
        chk("wr_n", wq_addr.size(), 2);
        chk("wr_a0", {28'b0, wq_addr[0]}, 3);
        chk("wr_a1", {28'b0, wq_addr[1]}, 4);
        chk("wr_d0", {24'b0, wq_data[0]}, 25);
        chk("wr_d1", {24'b0, wq_data[1]}, 40);
        read_burst(4'd3, 4'd1, 0);
        chk("rd_d0", {24'b0, rdq[0]}, 25);
        chk("rd_d1", {24'b0, rdq[1]}, 40);
        chk("rd_latency", first_rv - acc_cyc, 4);
        chk("done_cnt", done_cnt, 2);

        // full-rate read of 16 beats
        issue_cmd(1'b1, 4'd0, 4'd15);
        for (int i = 0; i < 16; i++) wr_beat(8'(i));
        wait_idle();
        read_burst(4'd0, 4'd15, 0);
        for (int i = 0; i < 16; i++) chk($sformatf("full_%0d", i), {24'b0, rdq[i]}, i);
        chk("full_latency", first_rv - acc_cyc, 4);
        chk("full_rate", last_pop - first_pop, 15);

        // backpressure, rd_ready 1,0,0 pattern
        read_burst(4'd0, 4'd15, 1);
        for (int i = 0; i < 16; i++) chk($sformatf("bp_%0d", i), {24'b0, rdq[i]}, i);
        chk("done_cnt_bp", done_cnt, 5);

        // reset during beat 2 of a 4-beat write at addr 8
        wq_addr.delete(); wq_data.delete();
        issue_cmd(1'b1, 4'd8, 4'd3);
        wr_beat(8'h11);
        wr_beat(8'h22);
        wr_valid = 1'b1; wr_data = 8'h33; rst = 1'b1;
        tick();
        chk("mid_rst_we", {31'b0, ram_we}, 0);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 1);
        rst = 1'b0; wr_valid = 1'b0;
        tick(); tick();
        chk("mid_rst_nwr", wq_addr.size(), 2);
        read_burst(4'd8, 4'd3, 0);
        chk("mid_rst_r0", {24'b0, rdq[0]}, 32'h11);
        chk("mid_rst_r1", {24'b0, rdq[1]}, 32'h22);
        chk("mid_rst_r2", {24'b0, rdq[2]}, 32'h0a);
        chk("mid_rst_r3", {24'b0, rdq[3]}, 32'h0b);

        // write-stream stall for 5 cycles
        wq_addr.delete(); wq_data.delete();
        issue_cmd(1'b1, 4'd5, 4'd2);
        wr_beat(8'h51);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_we_%0d", i), {31'b0, ram_we}, 0);
            tick();
        end
        wr_beat(8'h52);
        wr_beat(8'h53);
        wait_idle();
        chk("stall_n", wq_addr.size(), 3);
        chk("stall_a0", {28'b0, wq_addr[0]}, 5);
        chk("stall_a1", {28'b0, wq_addr[1]}, 6);
        chk("stall_a2", {28'b0, wq_addr[2]}, 7);
        read_burst(4'd5, 4'd2, 0);
        chk("stall_r0", {24'b0, rdq[0]}, 32'h51);
        chk("stall_r1", {24'b0, rdq[1]}, 32'h52);
        chk("stall_r2", {24'b0, rdq[2]}, 32'h53);

        // wrap at top of address space
        wq_addr.delete(); wq_data.delete();
        d0 = done_cnt;
`ifdef RAM_BOUND_CHK_EN
        issue_cmd(1'b1, 4'd14, 4'd3);
        chk("oob_err", {31'b0, err}, 1);
        tick(); tick(); tick();
        chk("oob_no_we", wq_addr.size(), 0);
        chk("oob_no_done", done_cnt, d0);
        chk("oob_err_cnt", err_cnt, 1);
        chk("oob_idle", {31'b0, cmd_ready}, 1);
`else
        issue_cmd(1'b1, 4'd14, 4'd3);
        wr_beat(8'hA1); wr_beat(8'hB2); wr_beat(8'hC3); wr_beat(8'hD4);
        wait_idle();
        chk("wrap_n", wq_addr.size(), 4);
        chk("wrap_a0", {28'b0, wq_addr[0]}, 14);
        chk("wrap_a1", {28'b0, wq_addr[1]}, 15);
        chk("wrap_a2", {28'b0, wq_addr[2]}, 0);
        chk("wrap_a3", {28'b0, wq_addr[3]}, 1);
        read_burst(4'd14, 4'd3, 0);
        chk("wrap_r0", {24'b0, rdq[0]}, 32'hA1);
        chk("wrap_r1", {24'b0, rdq[1]}, 32'hB2);
        chk("wrap_r2", {24'b0, rdq[2]}, 32'hC3);
        chk("wrap_r3", {24'b0, rdq[3]}, 32'hD4);
        chk("wrap_done", done_cnt, d0 + 2);
        chk("err_never", err_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
